// File: rtl/placar_pkg.sv
// Shared types and defaults for the placar score keeper.
package placar_pkg;

  typedef enum logic {IDLE, ADD} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int DEF_DIGITS     = 4;
  localparam int DEF_COMBO_STEP = 8;
  localparam int DEF_MAX_MULT   = 4;

  localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage

// File: rtl/placar_bcd_digit_add.sv
// One-digit BCD adder with carry.
// A binary sum above nine is pushed past the decimal wrap by adding six.
module bcd_digit_add
  import placar_pkg::*;
(
  input  bcd_digit_t i_a,
  input  bcd_digit_t i_b,
  input  logic       i_cin,
  output bcd_digit_t o_sum,
  output logic       o_cout
);

  logic [4:0] w_bin;
  logic [4:0] w_corr;

  assign w_bin  = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_cin};
  assign w_corr = w_bin + 5'd6;

  assign o_cout = (w_bin > 5'd9);
  assign o_sum  = o_cout ? w_corr[3:0] : w_bin[3:0];

endmodule

// File: rtl/placar.sv
// Rhythm-game score keeper.
// It tracks the hit combo and multiplier, and adds to a packed-BCD score one digit per cycle.
module placar
  import placar_pkg::*;
#(
  parameter int DIGITS     = DEF_DIGITS,
  parameter int COMBO_STEP = DEF_COMBO_STEP,
  parameter int MAX_MULT   = DEF_MAX_MULT
) (
  input  logic                  CLOCK_25,
  input  logic                  reset,
  input  logic                  ponto,
  input  logic                  erro,
  input  logic                  fim_de_jogo,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [7:0]            combo,
  output logic [2:0]            multiplicador,
  output logic                  busy,
  output logic                  saturado
);

  localparam int                    IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0]   ALL_NINES = {DIGITS{BCD_NINE}};

  state_t                r_state, w_state_next;
  logic                  r_ponto_q;
  logic [7:0]            r_combo;
  logic [2:0]            r_pending;
  bcd_digit_t            r_addend;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_carry;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   r_score;
  logic                  r_sat;

  logic                  w_hit, w_miss, w_start, w_last;
  logic [8:0]            w_mult_raw;
  bcd_digit_t            w_digit_a, w_digit_b, w_sum;
  logic                  w_cout;
  logic [4*DIGITS-1:0]   w_shadow_next;

  assign w_hit   = ponto & ~r_ponto_q & ~fim_de_jogo;
  assign w_miss  = erro & ~fim_de_jogo;
  assign w_start = (r_state == IDLE) && (r_pending != 3'd0);
  assign w_last  = (r_idx == LAST_IDX);

  assign w_mult_raw    = 9'(32'(r_combo) / COMBO_STEP) + 9'd1;
  assign multiplicador = (w_mult_raw > 9'(MAX_MULT)) ? 3'(MAX_MULT) : w_mult_raw[2:0];

  // The addend only enters digit 0; higher digits just absorb the carry.
  assign w_digit_a = r_score[{r_idx, 2'b00} +: 4];
  assign w_digit_b = (r_idx == '0) ? r_addend : bcd_digit_t'(4'd0);

  bcd_digit_add u_digit_add (
    .i_a    (w_digit_a),
    .i_b    (w_digit_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_shadow_next = r_shadow;
    w_shadow_next[{r_idx, 2'b00} +: 4] = w_sum;

    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_pending != 3'd0) w_state_next = ADD;
      ADD:     if (w_last)            w_state_next = IDLE;
      default:                        w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      r_ponto_q <= 1'b0;
      r_combo   <= 8'd0;
      r_pending <= 3'd0;
    end else begin
      r_ponto_q <= ponto;

      if (w_miss)                      r_combo <= 8'd0;
      else if (w_hit && r_combo != 8'hFF) r_combo <= r_combo + 8'd1;

      if (w_hit && w_start)               r_pending <= r_pending;
      else if (w_hit && r_pending != 3'd7) r_pending <= r_pending + 3'd1;
      else if (w_start)                    r_pending <= r_pending - 3'd1;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      r_addend <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_shadow <= '0;
      r_score  <= '0;
      r_sat    <= 1'b0;
    end else if (w_start) begin
      r_addend <= bcd_digit_t'({1'b0, multiplicador});
      r_idx    <= '0;
      r_carry  <= 1'b0;
    end else if (r_state == ADD) begin
      r_shadow <= w_shadow_next;
      r_carry  <= w_cout;
      r_idx    <= r_idx + 1'b1;
      if (w_last) begin
        if (w_cout || r_sat) begin
          r_score <= ALL_NINES;
          r_sat   <= 1'b1;
        end else begin
          r_score <= w_shadow_next;
        end
      end
    end
  end

  assign score_bcd = r_score;
  assign combo     = r_combo;
  assign busy      = (r_state == ADD);
  assign saturado  = r_sat;

endmodule

// File: tb/tb_placar.sv
// Self-checking bench for placar: vector table, scoreboard of committed scores, and multi-cycle corner sequences.
module tb_placar;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ponto = 1'b0, erro = 1'b0, fim = 1'b0;
  logic ponto2 = 1'b0, erro2 = 1'b0, fim2 = 1'b0;

  logic [15:0] score;
  logic [7:0]  combo;
  logic [2:0]  mult;
  logic        busy, sat;

  logic [7:0]  score2;
  logic [7:0]  combo2;
  logic [2:0]  mult2;
  logic        busy2, sat2;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  int          m_combo = 0;
  int          m_score = 0;
  bit          busy_prev = 1'b0;

  typedef struct {
    string       name;
    int          hits;
    bit          miss_only;
    bit          miss_on_hit;
    logic [7:0]  exp_combo;
    logic [2:0]  exp_mult;
    logic [15:0] exp_score;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  placar u_dut (
    .CLOCK_25      (clk),
    .reset         (reset),
    .ponto         (ponto),
    .erro          (erro),
    .fim_de_jogo   (fim),
    .score_bcd     (score),
    .combo         (combo),
    .multiplicador (mult),
    .busy          (busy),
    .saturado      (sat)
  );

  placar #(.DIGITS(2)) u_dut2 (
    .CLOCK_25      (clk),
    .reset         (reset),
    .ponto         (ponto2),
    .erro          (erro2),
    .fim_de_jogo   (fim2),
    .score_bcd     (score2),
    .combo         (combo2),
    .multiplicador (mult2),
    .busy          (busy2),
    .saturado      (sat2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int mmult(input int c);
    int m;
    m = 1 + c / 8;
    return (m > 4) ? 4 : m;
  endfunction

  task automatic model_hit(input bit with_miss);
    if (with_miss)         m_combo = 0;
    else if (m_combo < 255) m_combo = m_combo + 1;
    m_score = m_score + mmult(m_combo);
    if (m_score > 9999) m_score = 9999;
    exp_q.push_back(to_bcd(m_score));
  endtask

  // Scoreboard: a falling busy marks a fresh commit of the score.
  always @(negedge clk) begin
    if (!reset) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_commit: got 0x%0h expected no commit", score);
        end else begin
          check("commit_score", score, exp_q.pop_front());
        end
      end
      busy_prev = busy;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    m_combo = 0;
    m_score = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic hit1(input bit with_erro);
    @(posedge clk);
    #1 ponto = 1'b1; erro = with_erro;
    model_hit(with_erro);
    @(posedge clk);
    #1 ponto = 1'b0; erro = 1'b0;
    repeat (7) @(posedge clk);
  endtask

  task automatic miss1();
    @(posedge clk);
    #1 erro = 1'b1;
    m_combo = 0;
    @(posedge clk);
    #1 erro = 1'b0;
  endtask

  task automatic hit2();
    @(posedge clk);
    #1 ponto2 = 1'b1;
    @(posedge clk);
    #1 ponto2 = 1'b0;
    repeat (7) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d outstanding commits expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_j, busy_cnt, first_b, last_b;
    logic [7:0]  pat;

    vecs[0] = '{"nine_hits",   9, 1'b0, 1'b0, 8'd9,  3'd2, 16'h0011};
    vecs[1] = '{"twenty_hits", 11, 1'b0, 1'b0, 8'd20, 3'd3, 16'h0038};
    vecs[2] = '{"miss",        0, 1'b1, 1'b0, 8'd0,  3'd1, 16'h0038};
    vecs[3] = '{"hit_and_miss", 1, 1'b0, 1'b1, 8'd0,  3'd1, 16'h0039};
    vecs[4] = '{"more_hits",   25, 1'b0, 1'b0, 8'd25, 3'd4, 16'h0094};

    do_reset();
    @(negedge clk);
    check("rst_score", score, 16'h0000);
    check("rst_combo", combo, 8'd0);
    check("rst_mult",  mult,  3'd1);
    check("rst_busy",  busy,  1'b0);
    check("rst_sat",   sat,   1'b0);

    // Held level: one edge, one hit, latency DIGITS+2.
    @(posedge clk);
    #1 ponto = 1'b1;
    model_hit(1'b0);
    first_j  = -1;
    busy_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (j == 1) check("held_combo_n1", combo, 8'd1);
      if (first_j < 0 && score != 16'h0000) first_j = j;
    end
    check("held_latency",  first_j,  6);
    check("held_busy_cyc", busy_cnt, 4);
    check("held_score",    score,    16'h0001);
    check("held_combo",    combo,    8'd1);
    @(posedge clk);
    #1 ponto = 1'b0;
    wait_idle("held");

    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].miss_only) miss1();
      for (int h = 0; h < vecs[i].hits; h++) hit1(vecs[i].miss_on_hit);
      wait_idle(vecs[i].name);
      check({vecs[i].name, "_combo"}, combo, vecs[i].exp_combo);
      check({vecs[i].name, "_mult"},  mult,  vecs[i].exp_mult);
      check({vecs[i].name, "_score"}, score, vecs[i].exp_score);
    end

    // Burst of three edges two cycles apart.
    do_reset();
    pat = 8'b0001_0101;
    busy_cnt = 0; first_b = -1; last_b = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (c < 8) begin
        ponto = pat[c];
        if (pat[c]) model_hit(1'b0);
      end
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (first_b < 0) first_b = c;
        last_b = c;
      end
    end
    wait_idle("burst");
    check("burst_busy_cyc", busy_cnt, 12);
    check("burst_span",     last_b - first_b + 1, 14);
    check("burst_combo",    combo, 8'd3);
    check("burst_score",    score, 16'h0003);

    // End of game raised mid-burst: edges after it are ignored.
    do_reset();
    pat = 8'b0101_0101;
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 3)  fim = 1'b1;
      if (c == 12) fim = 1'b0;
      if (c < 8) begin
        ponto = pat[c];
        if (pat[c] && c < 3) model_hit(1'b0);
      end
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    wait_idle("fim");
    check("fim_busy_cyc", busy_cnt, 8);
    check("fim_combo",    combo, 8'd2);
    check("fim_score",    score, 16'h0002);

    // Reset pulsed while an addition is in flight.
    do_reset();
    @(posedge clk);
    #1 ponto = 1'b1;
    model_hit(1'b0);
    @(posedge clk);
    #1 ponto = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy",  busy,  1'b0);
    check("midrst_score", score, 16'h0000);
    check("midrst_combo", combo, 8'd0);
    exp_q.delete();
    m_combo = 0;
    m_score = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    hit1(1'b0);
    wait_idle("after_midrst");
    check("after_midrst_score", score, 16'h0001);

    // Two-digit instance: 40 hits total 115, which saturates at 99.
    do_reset();
    for (int h = 0; h < 30; h++) hit2();
    check("ovf_pre_score", score2, 8'h75);
    check("ovf_pre_sat",   sat2,   1'b0);
    for (int h = 0; h < 10; h++) hit2();
    check("ovf_score", score2, 8'h99);
    check("ovf_sat",   sat2,   1'b1);
    for (int h = 0; h < 2; h++) hit2();
    check("ovf_hold_score", score2, 8'h99);
    check("ovf_hold_sat",   sat2,   1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
